snac_userport_responder: RTL
============================

# snac_userport_responder

Device-side model of the two-player SNAC joystick adapter on the MiSTer user port. The core drives a player-select line out of the user port, and this block answers on the 8-bit user-port input bus with the selected player's active-low button and paddle-comparator pattern. It sits between the controller sources and the core's user-port input, so SNAC capture can be closed in loopback on a second board or in the system bench. It synchronises the select line, debounces buttons, applies a mux settle delay, and drives released (all-ones) pins at reset.

## Interface
- SETTLE_CYCLES, 4 — clk_sys cycles between a recognised select edge and presenting the new player (0..255)
- DEBOUNCE_CYCLES, 16 — consecutive stable cycles before a filtered button bit changes (1..65535)
- clk_sys  in  1  system clock; only clock
- reset  in  1  synchronous, active-high reset
- sel_in  in  1  player select from the core's user-port output bit 4; 1 = player 1, 0 = player 2; asynchronous
- two_player  in  1  0 = single-adapter mode, select ignored, player 1 always driven
- pad_mode  in  1  1 = pins 1/2 carry paddle comparators instead of left/right
- p1_btn, p2_btn  in  5 each  {fire, up, down, left, right}, active-high, asynchronous
- p1_pad, p2_pad  in  2 each  {right-comparator, left-comparator}, active-high, synchronous to clk_sys
- user_in  out  8  registered active-low pin pattern to the core's user-port input
- settling  out  1  high while the settle counter is non-zero
- sel_edges  out  16  count of recognised select edges; wraps at 0xFFFF→0

## Operation
- Pin map (active-low, 0 = pressed): right→pin 2, left→pin 1, down→pin 7, up→pin 5, fire→pin 3. In pad_mode, pin 1 = ~pad[0] and pin 2 = ~pad[1]. Pins 0, 4, 6 are always 1.
- Select sync: two-flop synchroniser on sel_in, with both flops reset to 1. A third register holds the previous synced value, and an edge is any difference between them. Edges are ignored when two_player = 0: the edge counter does not count them and settle does not start.
- Debounce: 10 independent button filters, each with its own counter. When the raw bit differs from its filtered value, the counter increments; when the raw bit equals the filtered value, the counter clears. When the count reaches DEBOUNCE_CYCLES, the filtered value flips and the counter clears. Paddle bits bypass debounce.
- Target player: the synced select when two_player = 1, otherwise player 1.
- Settle: an edge loads the counter with SETTLE_CYCLES. The counter decrements each cycle while non-zero. An edge arriving mid-settle reloads the counter, and the target follows the latest edge.
- Output register: when the counter is zero, user_in loads the mapped pattern of the target player every cycle. While the counter is non-zero, the register behaves as described under Configuration.
- sel_edges increments by one per recognised edge.

## Timing
- Reset values: user_in = 8'hFF, settling = 0, sel_edges = 0, all filtered buttons released, settle counter 0, synchroniser = 1.
- Select latency: sel_in changes before edge N. The edge is recognised in cycle N+2, and the counter loads at N+3. user_in shows the new player at N+3+SETTLE_CYCLES. With SETTLE_CYCLES = 0, user_in shows the new player at N+3 and settling never asserts.
- Steady-state button latency: DEBOUNCE_CYCLES + 1 cycles from raw change to user_in.
- Steady-state paddle latency: 1 cycle.
- Raw toggle shorter than DEBOUNCE_CYCLES: no output change.
- two_player falling mid-settle: the counter clears the next cycle and player 1 is driven.
- Reset asserted mid-settle or mid-debounce: all state returns to its reset values at the next edge.

## Configuration
- SNAC_RESP_BLANK_EN defined: while settling = 1, user_in = 8'hFF (all released), which models an adapter mux that floats during switching.
- SNAC_RESP_BLANK_EN undefined: while settling = 1, user_in holds its last value.
- In both cases, the post-settle behaviour is identical.

## Test plan
- Reset check, with DEBOUNCE_CYCLES = 16: after reset with every input at 0, user_in = 8'hFF. Hold p1 fire high for 16 cycles: pin 3 goes low at cycle 17, so user_in = 8'hF7.
- Select switch: two_player = 1, SETTLE_CYCLES = 4, p1 up held, p2 down held, sel_in toggled 1→0. user_in changes from 8'hDF to 8'h7F exactly 7 cycles after the toggle, settling is high for 4 cycles, and sel_edges = 1.
- Settle behaviour under the macro: with SNAC_RESP_BLANK_EN defined, repeat the select switch and check user_in = 8'hFF during settle. With the macro undefined, check user_in holds 8'hDF during settle.
- Glitch rejection: a 10-cycle p2 left pulse leaves user_in unchanged. A re-toggle of sel_in during settle reloads the counter, and sel_edges counts 2.
- Paddle mode: pad_mode = 1 with p1_pad = 2'b10 gives pin 2 low (user_in = 8'hFB) one cycle later, even while p1 right is debouncing.
- Single-player mode and edge counter: with two_player = 0, toggling sel_in 100 times leaves sel_edges = 0 and player 1 driven. Separately, with two_player = 1, force 65536 edges and check sel_edges wraps to 0.

Source files
------------

// File: rtl/snac_userport_responder.sv
// SNAC two-player joystick adapter model driving the MiSTer user-port input bus.
// Optional SNAC_RESP_BLANK_EN: pins read all-released (8'hFF) while the mux settles.
module snac_userport_responder #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        sel_in,
  input  logic        two_player,
  input  logic        pad_mode,
  input  logic [4:0]  p1_btn,
  input  logic [4:0]  p2_btn,
  input  logic [1:0]  p1_pad,
  input  logic [1:0]  p2_pad,
  output logic [7:0]  user_in,
  output logic        settling,
  output logic [15:0] sel_edges
);

  localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [16:0] DB_LIMIT    = 17'(DEBOUNCE_CYCLES);

  logic        sync1_r;
  logic        sync2_r;
  logic        prev_r;
  logic        edge_r;
  logic [7:0]  settle_r;
  logic [7:0]  settle_next_s;
  logic [9:0]  raw_s;
  logic [9:0]  filt_r;
  logic [15:0] db_cnt_r [10];
  logic        p2_sel_s;
  logic [7:0]  pattern_s;

  // Active-low pin image: pins 0/4/6 idle high; pins 1/2 swap to paddle comparators in pad mode.
  function automatic logic [7:0] map_pins(input logic [4:0] btn, input logic [1:0] pad,
                                          input logic use_pad);
    logic left_s;
    logic right_s;
    left_s  = use_pad ? pad[0] : btn[1];
    right_s = use_pad ? pad[1] : btn[0];
    return ~{btn[2], 1'b0, btn[3], 1'b0, btn[4], right_s, left_s, 1'b0};
  endfunction

  assign raw_s = {p2_btn, p1_btn};

  // Select synchroniser, previous-value register and registered edge flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= sel_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      edge_r  <= two_player & (sync2_r != prev_r);
    end
  end

  // Per-button debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_r <= 10'd0;
      for (int i = 0; i < 10; i++) begin
        db_cnt_r[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (raw_s[i] == filt_r[i]) begin
          db_cnt_r[i] <= 16'd0;
        end else if (({1'b0, db_cnt_r[i]} + 17'd1) == DB_LIMIT) begin
          filt_r[i]   <= ~filt_r[i];
          db_cnt_r[i] <= 16'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 16'd1;
        end
      end
    end
  end

  // Settle counter next state; leaving two-player mode cancels any pending settle.
  always_comb begin
    settle_next_s = settle_r;
    if (!two_player) begin
      settle_next_s = 8'd0;
    end else if (edge_r) begin
      settle_next_s = SETTLE_INIT;
    end else if (settle_r != 8'd0) begin
      settle_next_s = settle_r - 8'd1;
    end else begin
      settle_next_s = 8'd0;
    end
  end

  // Target player pattern; prev_r lags the synchroniser so the switch lines up with the counter load.
  always_comb begin
    p2_sel_s  = two_player & ~prev_r;
    pattern_s = 8'hFF;
    if (p2_sel_s) begin
      pattern_s = map_pins(filt_r[9:5], p2_pad, pad_mode);
    end else begin
      pattern_s = map_pins(filt_r[4:0], p1_pad, pad_mode);
    end
  end

  // Registered outputs: settle state, edge counter and the pin pattern.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      settle_r  <= 8'd0;
      settling  <= 1'b0;
      sel_edges <= 16'd0;
      user_in   <= 8'hFF;
    end else begin
      settle_r <= settle_next_s;
      settling <= (settle_next_s != 8'd0);
      if (edge_r && two_player) begin
        sel_edges <= sel_edges + 16'd1;
      end else begin
        sel_edges <= sel_edges;
      end
      if (settle_next_s == 8'd0) begin
        user_in <= pattern_s;
      end else begin
`ifdef SNAC_RESP_BLANK_EN
        user_in <= 8'hFF;
`else
        user_in <= user_in;
`endif
      end
    end
  end

endmodule
